seq_alu: RTL

- Parametrised, multi-cycle successor to the core integer ALU.
- Covers the full base op set: add, sub, and, or, xor, sll, srl, sra, slt, sltu. Adds the M-extension ops: mul, mulh, mulhu, div, divu, rem, remu.
- Base ops use a registered single-cycle path. Multiply and divide use an iterative radix-2 datapath.
- Sits in the execute stage behind a valid/ready handshake so the pipeline can stall on long ops.

---
 rtl/seq_alu_if.sv | 25 ++
 rtl/seq_alu.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/seq_alu_if.sv
// Request/result handshake bundle for seq_alu: operand request in, result out, plus kill/busy.
interface seq_alu_if #(
  parameter int unsigned XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      alu_op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            kill;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_data;
  logic            busy;

  modport master (
    output in_valid, alu_op, a, b, kill, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, alu_op, a, b, kill, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle integer ALU: registered single-cycle base ops, radix-2 iterative mul/div/rem.
module seq_alu #(
  parameter int unsigned XLEN = 64,
  localparam int unsigned SHW = $clog2(XLEN)
) (
  input logic        clk,
  input logic        rst_n,
  seq_alu_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            r_state, w_state_d;
  logic [XLEN-1:0]   r_acc, r_q, r_opa, r_out;
  logic [4:0]        r_op;
  logic              r_neg;
  logic [SHW-1:0]    r_count;

  logic              w_accept, w_is_long, w_div_op, w_div_zero, w_div_ovf, w_signed_op;
  logic              w_neg_init, w_last, w_iter, w_is_mul;
  logic [SHW-1:0]    w_shamt;
  logic [XLEN-1:0]   w_base, w_special, w_min, w_a_mag, w_b_mag, w_final;
  logic [XLEN-1:0]   w_acc_n, w_q_n;
  logic [XLEN:0]     w_mul_sum, w_div_sh, w_div_diff;
  logic [2*XLEN-1:0] w_prod, w_prod_c;

  assign bus.in_ready  = rst_n && (r_state == StIdle);
  assign bus.out_valid = (r_state == StDone);
  assign bus.busy      = (r_state == StBusy);
  assign bus.out_data  = r_out;

  assign w_accept    = bus.in_valid && bus.in_ready && !bus.kill;
  assign w_is_long   = (bus.alu_op >= 5'd10) && (bus.alu_op <= 5'd16);
  assign w_div_op    = (bus.alu_op >= 5'd13) && (bus.alu_op <= 5'd16);
  assign w_min       = {1'b1, {(XLEN-1){1'b0}}};
  assign w_div_zero  = w_div_op && (bus.b == '0);
  assign w_div_ovf   = ((bus.alu_op == 5'd13) || (bus.alu_op == 5'd15)) &&
                       (bus.a == w_min) && (bus.b == '1);
  assign w_signed_op = (bus.alu_op == 5'd11) || (bus.alu_op == 5'd13) || (bus.alu_op == 5'd15);
  assign w_a_mag     = (w_signed_op && bus.a[XLEN-1]) ? -bus.a : bus.a;
  assign w_b_mag     = (w_signed_op && bus.b[XLEN-1]) ? -bus.b : bus.b;
  assign w_shamt     = bus.b[SHW-1:0];
  assign w_iter      = (r_state == StBusy) && !bus.kill;
  assign w_last      = (r_count == SHW'(XLEN - 1));
  assign w_is_mul    = (r_op <= 5'd12);

  // Remainder takes the dividend's sign; quotient and mulh take the XOR of both signs.
  always_comb begin
    w_neg_init = 1'b0;
    if ((bus.alu_op == 5'd11) || (bus.alu_op == 5'd13)) begin
      w_neg_init = bus.a[XLEN-1] ^ bus.b[XLEN-1];
    end else if (bus.alu_op == 5'd15) begin
      w_neg_init = bus.a[XLEN-1];
    end
  end

  always_comb begin
    w_base = '0;
    case (bus.alu_op)
      5'd0:    w_base = bus.a + bus.b;
      5'd1:    w_base = bus.a - bus.b;
      5'd2:    w_base = bus.a & bus.b;
      5'd3:    w_base = bus.a | bus.b;
      5'd4:    w_base = bus.a ^ bus.b;
      5'd5:    w_base = bus.a << w_shamt;
      5'd6:    w_base = bus.a >> w_shamt;
      5'd7:    w_base = $signed(bus.a) >>> w_shamt;
      5'd8:    w_base = {{(XLEN-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      5'd9:    w_base = {{(XLEN-1){1'b0}}, (bus.a < bus.b)};
      default: w_base = '0;
    endcase
  end

  always_comb begin
    w_special = '0;
    if (w_div_zero) begin
      w_special = ((bus.alu_op == 5'd13) || (bus.alu_op == 5'd14)) ? '1 : bus.a;
    end else if (w_div_ovf) begin
      w_special = (bus.alu_op == 5'd13) ? bus.a : '0;
    end
  end

  // Shared datapath: {r_acc, r_q} is the product for mul, {remainder, quotient} for div.
  assign w_mul_sum  = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_opa} : '0);
  assign w_div_sh   = {r_acc, r_q[XLEN-1]};
  assign w_div_diff = w_div_sh - {1'b0, r_opa};

  always_comb begin
    w_acc_n = w_div_sh[XLEN-1:0];
    w_q_n   = {r_q[XLEN-2:0], 1'b0};
    if (w_is_mul) begin
      w_acc_n = w_mul_sum[XLEN:1];
      w_q_n   = {w_mul_sum[0], r_q[XLEN-1:1]};
    end else if (!w_div_diff[XLEN]) begin
      w_acc_n = w_div_diff[XLEN-1:0];
      w_q_n   = {r_q[XLEN-2:0], 1'b1};
    end
  end

  assign w_prod   = {w_acc_n, w_q_n};
  assign w_prod_c = r_neg ? -w_prod : w_prod;

  always_comb begin
    w_final = '0;
    case (r_op)
      5'd10:        w_final = w_prod_c[XLEN-1:0];
      5'd11, 5'd12: w_final = w_prod_c[2*XLEN-1:XLEN];
      5'd13, 5'd14: w_final = r_neg ? -w_q_n : w_q_n;
      5'd15, 5'd16: w_final = r_neg ? -w_acc_n : w_acc_n;
      default:      w_final = '0;
    endcase
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_d = (w_is_long && !w_div_zero && !w_div_ovf) ? StBusy : StDone;
        end
      end
      StBusy: begin
        if (bus.kill)    w_state_d = StIdle;
        else if (w_last) w_state_d = StDone;
      end
      StDone: begin
        if (bus.kill || bus.out_ready) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_q     <= '0;
      r_opa   <= '0;
      r_out   <= '0;
      r_op    <= '0;
      r_neg   <= 1'b0;
      r_count <= '0;
    end else if (w_accept) begin
      r_op    <= bus.alu_op;
      r_count <= '0;
      r_acc   <= '0;
      r_q     <= w_a_mag;
      r_opa   <= w_b_mag;
      r_neg   <= w_neg_init;
      if (!w_is_long) begin
        r_out <= w_base;
      end else if (w_div_zero || w_div_ovf) begin
        r_out <= w_special;
      end
    end else if (w_iter) begin
      r_acc   <= w_acc_n;
      r_q     <= w_q_n;
      r_count <= r_count + SHW'(1);
      if (w_last) r_out <= w_final;
    end
  end

endmodule
